// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Signal bundle between the fetch unit, instruction memory, the redirect
//   source and the decoder.
//
//   Handshake rule (applies to both imem_req_* and instr_*): a transfer
//   happens on a rising clk edge where valid and ready are both 1. While
//   valid is 1 and ready is 0, the payload is held stable. imem_rsp_valid_i
//   has no ready. Memory returns one word per accepted request, in request
//   order, at least one cycle after the accept.
//
//   master : fetch unit side      slave : environment side
//   imem_req_valid_o / imem_req_addr_o / imem_req_ready_i   read request
//   imem_rsp_valid_i / imem_rsp_data_i                      read response
//   redirect_i / redirect_pc_i                              PC steering
//   instr_valid_o / instr_o / instr_pc_o / instr_pc_plus4_o
//   / instr_ready_i                                         decode side
//   misalign_o                                              redirect target not word aligned
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req_valid_o;
    logic [ADDR_WIDTH-1:0] imem_req_addr_o;
    logic                  imem_req_ready_i;
    logic                  imem_rsp_valid_i;
    logic [31:0]           imem_rsp_data_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic [ADDR_WIDTH-1:0] instr_pc_plus4_o;
    logic                  instr_ready_i;
    logic                  misalign_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
        input  instr_ready_i,
        output misalign_o
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
        output instr_ready_i,
        input  misalign_o
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: holds the PC, issues in-order word reads to instruction
//   memory, pairs each returned word with the PC it was fetched from, and
//   offers it to decode. A redirect steers the PC, flushes buffered words and
//   discards responses of requests that were already in flight.
//
// Ports
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous reset, active high
//   bus        instr_fetch_unit_if.master (memory, redirect and decode side)
//   dbg_state  current FSM state (0 BOOT, 1 RUN, 2 DRAIN)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_unit_if.master bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW      = PW + 1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         drop, drop_next;
    logic                  misalign_q;

    // PC tags of requests in flight, consumed in response order.
    logic [ADDR_WIDTH-1:0] tag_mem [DEPTH];
    logic [PW-1:0]         tag_wr, tag_rd;

    // Returned instructions waiting for decode.
    logic [ADDR_WIDTH-1:0] ifq_pc   [DEPTH];
    logic [31:0]           ifq_data [DEPTH];
    logic [PW-1:0]         ifq_wr, ifq_rd;
    logic [CW-1:0]         ifq_count;

    logic                  redirect_act, rsp_take, instr_valid, push, pop;
    logic                  req_valid, req_fire;
    logic [CW:0]           occupancy;
    logic [ADDR_WIDTH-1:0] head_pc;

    assign redirect_act = bus.redirect_i && (state != BOOT);
    // A response with nothing outstanding cannot belong to us (e.g. left over
    // from before reset), so it never underflows the counter.
    assign rsp_take     = bus.imem_rsp_valid_i && (inflight != '0);
    assign instr_valid  = (ifq_count != '0);
    assign pop          = instr_valid && bus.instr_ready_i;
    assign push         = rsp_take && (state == RUN) && !redirect_act;

    // Credit: every request reserves a buffer slot. The word leaving to decode
    // this cycle frees its slot now, which keeps one fetch per cycle with
    // DEPTH=2 and a single-cycle memory.
    assign occupancy = {1'b0, inflight} + {1'b0, ifq_count} - {{CW{1'b0}}, pop};

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        req_fire   = 1'b0;
        drop_next  = drop;
        unique case (state)
            BOOT:  state_next = RUN;
            RUN:   req_valid = (occupancy < DEPTH_C);
            DRAIN: begin
                if (rsp_take) drop_next = drop - CW'(1);
                if (drop_next == '0) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
        req_fire = req_valid && bus.imem_req_ready_i;
        // Everything outstanding after this edge is wrong-path, including a
        // request accepted in the redirect cycle itself.
        if (redirect_act) begin
            drop_next  = inflight + CW'(req_fire) - CW'(rsp_take);
            state_next = (drop_next != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            inflight   <= '0;
            drop       <= '0;
            misalign_q <= 1'b0;
            tag_wr     <= '0;
            tag_rd     <= '0;
            ifq_wr     <= '0;
            ifq_rd     <= '0;
            ifq_count  <= '0;
        end else begin
            state      <= state_next;
            drop       <= drop_next;
            inflight   <= inflight + CW'(req_fire) - CW'(rsp_take);
            misalign_q <= redirect_act && (bus.redirect_pc_i[1:0] != 2'b00);
            if (redirect_act) begin
                pc <= {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (redirect_act) begin
                tag_wr    <= '0;
                tag_rd    <= '0;
                ifq_wr    <= '0;
                ifq_rd    <= '0;
                ifq_count <= '0;
            end else begin
                if (req_fire) tag_wr <= tag_wr + PW'(1);
                if (push) begin
                    tag_rd <= tag_rd + PW'(1);
                    ifq_wr <= ifq_wr + PW'(1);
                end
                if (pop) ifq_rd <= ifq_rd + PW'(1);
                ifq_count <= ifq_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: pointers and counts decide what is visible.
    always_ff @(posedge clk_i) begin
        if (req_fire) tag_mem[tag_wr] <= pc;
        if (push) begin
            ifq_pc[ifq_wr]   <= tag_mem[tag_rd];
            ifq_data[ifq_wr] <= bus.imem_rsp_data_i;
        end
    end

    assign head_pc = instr_valid ? ifq_pc[ifq_rd] : '0;

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = pc;
    assign bus.instr_valid_o    = instr_valid;
    assign bus.instr_o          = instr_valid ? ifq_data[ifq_rd] : 32'h0;
    assign bus.instr_pc_o       = head_pc;
    assign bus.instr_pc_plus4_o = head_pc + ADDR_WIDTH'(4);
    assign bus.misalign_o       = misalign_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus knobs, applied at the start of each tick
    logic        mem_ready = 1'b1;
    logic        dec_ready = 1'b1;
    logic        redir     = 1'b0;
    logic [31:0] redir_pc  = 32'h0;
    int          mem_lat   = 1;

    // instruction memory environment: accepted addresses with due cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // reference model: what fetch must look like from the outside
    bit          m_boot = 1'b1;
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_if_addr[$];
    bit          m_if_stale[$];
    logic [31:0] m_fq_pc[$];
    logic [31:0] m_fq_data[$];
    bit          m_mis  = 1'b0;

    // in-order consumption scoreboard
    logic [31:0] exp_q[$];
    bit          sb_on = 1'b0;

    // snapshot of the last ticked cycle, for hand-computed checks
    logic        s_iv, s_rv, s_mis;
    logic [31:0] s_pc, s_p4, s_instr, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    function automatic bit model_draining();
        bit d = 1'b0;
        foreach (m_if_stale[i]) if (m_if_stale[i]) d = 1'b1;
        return d;
    endfunction

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver + compare, one clock per call ----------------
    task automatic tick();
        logic        e_iv, e_rv, pop, fire, rsp, st;
        logic [31:0] a;
        int          occ;
        bus.imem_req_ready_i = mem_ready;
        bus.instr_ready_i    = dec_ready;
        bus.redirect_i       = redir;
        bus.redirect_pc_i    = redir_pc;
        rsp = !rst && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        bus.imem_rsp_valid_i = rsp;
        bus.imem_rsp_data_i  = rsp ? mem_word(mq_addr[0]) : 32'h0;

        @(negedge clk);
        e_iv = (m_fq_pc.size() > 0);
        pop  = e_iv && dec_ready;
        occ  = m_if_addr.size() + m_fq_pc.size() - (pop ? 1 : 0);
        e_rv = !m_boot && !model_draining() && (occ < DEPTH);

        check_bit("instr_valid", bus.instr_valid_o, e_iv);
        if (e_iv) begin
            check_word("instr_pc", bus.instr_pc_o, m_fq_pc[0]);
            check_word("instr", bus.instr_o, m_fq_data[0]);
            check_word("instr_pc_plus4", bus.instr_pc_plus4_o, m_fq_pc[0] + 32'd4);
        end
        check_bit("req_valid", bus.imem_req_valid_o, e_rv);
        if (e_rv) check_word("req_addr", bus.imem_req_addr_o, m_pc);
        check_bit("misalign", bus.misalign_o, m_mis);

        s_iv = bus.instr_valid_o;  s_rv = bus.imem_req_valid_o;  s_mis = bus.misalign_o;
        s_pc = bus.instr_pc_o;     s_p4 = bus.instr_pc_plus4_o;  s_instr = bus.instr_o;
        s_addr = bus.imem_req_addr_o;

        if (sb_on && bus.instr_valid_o && dec_ready) begin
            if (exp_q.size() == 0) check_bit("sb_underflow", 1'b1, 1'b0);
            else check_word("sb_pc", bus.instr_pc_o, exp_q.pop_front());
        end

        // memory reacts to what the DUT actually did
        fire = bus.imem_req_valid_o && mem_ready;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (rsp) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (fire) begin
                mq_addr.push_back(bus.imem_req_addr_o);
                mq_due.push_back(cyc + mem_lat);
            end
        end

        // model advances across the coming edge
        if (rst) begin
            m_boot = 1'b1;
            m_pc   = RESET_PC;
            m_if_addr.delete();  m_if_stale.delete();
            m_fq_pc.delete();    m_fq_data.delete();
            m_mis  = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
        end else begin
            st = 1'b1;
            a  = 32'h0;
            if (rsp) begin
                if (m_if_addr.size() == 0) check_bit("model_rsp_unexpected", 1'b1, 1'b0);
                else begin
                    a  = m_if_addr.pop_front();
                    st = m_if_stale.pop_front();
                end
            end
            if (pop) begin
                void'(m_fq_pc.pop_front());
                void'(m_fq_data.pop_front());
            end
            if (rsp && !st && !redir) begin
                m_fq_pc.push_back(a);
                m_fq_data.push_back(mem_word(a));
            end
            if (e_rv && mem_ready) begin
                m_if_addr.push_back(m_pc);
                m_if_stale.push_back(redir);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                foreach (m_if_stale[i]) m_if_stale[i] = 1'b1;
                m_fq_pc.delete();
                m_fq_data.delete();
                m_pc = {redir_pc[31:2], 2'b00};
            end
            m_mis = redir && (redir_pc[1:0] != 2'b00);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // tick until the model holds exactly n clean requests in flight
    task automatic wait_inflight(input int n, input string name);
        int k = 0;
        while (!(m_if_addr.size() == n && !model_draining()) && k < 20) begin
            tick();
            k++;
        end
        check_bit(name, (m_if_addr.size() == n) ? 1'b1 : 1'b0, 1'b1);
    endtask

    // tick until an instruction is shown, then pin its PC and link value
    task automatic wait_first_valid(input logic [31:0] pc, input string name);
        int k = 0;
        s_iv = 1'b0;
        while (!s_iv && k < 30) begin
            tick();
            k++;
        end
        check_bit({name, "_seen"}, s_iv, 1'b1);
        check_word({name, "_pc"}, s_pc, pc);
        check_word({name, "_pc_plus4"}, s_p4, pc + 32'd4);
        check_word({name, "_instr"}, s_instr, mem_word(pc));
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int          first_valid;
        int          fires;
        int          consumed;
        logic [31:0] pcs[16];

        bus.imem_req_ready_i = 1'b1;
        bus.instr_ready_i    = 1'b1;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = 32'h0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        tick();
        check_bit("rst_req_valid", s_rv, 1'b0);
        check_word("rst_req_addr", s_addr, RESET_PC);
        check_bit("rst_instr_valid", s_iv, 1'b0);
        check_word("rst_instr", s_instr, 32'h0);
        check_word("rst_instr_pc", s_pc, 32'h0);
        check_word("rst_instr_pc_plus4", s_p4, 32'h4);
        check_bit("rst_misalign", s_mis, 1'b0);

        // 1: streaming from reset with a 1-cycle memory
        for (int i = 0; i < 40; i++) exp_q.push_back(32'(4 * i));
        sb_on = 1'b1;
        rst = 1'b0;
        first_valid = -1;
        for (int t = 0; t < 12; t++) begin
            tick();
            pcs[t] = s_iv ? s_pc : 32'hFFFF_FFFF;
            if (s_iv && first_valid < 0) first_valid = t;
        end
        // BOOT cycle, request accept, response capture: shown after the third edge
        check_word("first_valid_cycle", 32'(first_valid), 32'd3);
        check_word("stream_pc0", pcs[3], 32'h0);
        check_word("stream_pc1", pcs[4], 32'h4);
        check_word("stream_pc2", pcs[5], 32'h8);
        check_word("stream_pc3", pcs[6], 32'hC);

        // 2: decode stalls for 5 cycles
        dec_ready = 1'b0;
        fires = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (s_rv && mem_ready) fires++;
        end
        check_bit("stall_req_bound", (fires <= DEPTH) ? 1'b1 : 1'b0, 1'b1);
        check_bit("stall_holds_instr", s_iv, 1'b1);
        check_bit("stall_no_req", s_rv, 1'b0);
        dec_ready = 1'b1;
        repeat (10) tick();
        sb_on = 1'b0;
        consumed = 40 - exp_q.size();
        check_bit("stall_progress", (consumed >= 12) ? 1'b1 : 1'b0, 1'b1);

        // 3: redirect with two requests in flight
        mem_lat = 3;
        wait_inflight(2, "t3_two_inflight");
        redir = 1'b1;
        redir_pc = 32'h0000_0100;
        tick();
        redir = 1'b0;
        check_bit("t3_drain_no_req", s_rv, 1'b0);
        wait_first_valid(32'h0000_0100, "t3");

        // 4: redirect in the same cycle as an accept and a response
        mem_lat = 1;
        repeat (6) tick();
        wait_inflight(1, "t4_steady");
        redir = 1'b1;
        redir_pc = 32'h0000_0200;
        tick();
        redir = 1'b0;
        tick();
        check_bit("t4_drain_no_req", s_rv, 1'b0);
        check_bit("t4_flushed", s_iv, 1'b0);
        tick();
        check_bit("t4_resume_req", s_rv, 1'b1);
        check_word("t4_resume_addr", s_addr, 32'h0000_0200);
        wait_first_valid(32'h0000_0200, "t4");

        // 5: misaligned redirect target
        repeat (3) tick();
        redir = 1'b1;
        redir_pc = 32'h0000_0102;
        tick();
        redir = 1'b0;
        tick();
        check_bit("t5_misalign_pulse", s_mis, 1'b1);
        tick();
        check_bit("t5_misalign_clear", s_mis, 1'b0);
        wait_first_valid(32'h0000_0100, "t5");

        // 6: reset while draining
        mem_lat = 3;
        wait_inflight(2, "t6_two_inflight");
        redir = 1'b1;
        redir_pc = 32'h0000_0300;
        tick();
        redir = 1'b0;
        rst = 1'b1;
        tick();
        check_bit("t6_drain_no_req", s_rv, 1'b0);
        rst = 1'b0;
        mem_lat = 1;
        tick();
        check_bit("t6_boot_no_valid", s_iv, 1'b0);
        check_bit("t6_boot_no_req", s_rv, 1'b0);
        wait_first_valid(RESET_PC, "t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
